// File: rtl/divider_voice_scheduler.sv
// Round-robin scheduler sharing one sequential divider across NUM_VOICES oscillator voices.
// Define DIV_SCHED_ROTATE_EN to rotate the first-serviced voice after every completed round.
module divider_voice_scheduler #(
   parameter int NUM_VOICES  = 4,
   parameter int DIV_LATENCY = 10
) (
   input  logic                     clk,
   input  logic                     nrst,
   input  logic                     sample_tick,
   input  logic [NUM_VOICES-1:0]    voice_en,
   input  logic [NUM_VOICES*16-1:0] osc_count,
   input  logic [NUM_VOICES*16-1:0] osc_divisor,
   input  logic                     overrun_clr,
   output logic                     div_sample_now,
   output logic [15:0]              div_dividend,
   output logic [15:0]              div_divisor,
   input  logic [7:0]               div_q,
   output logic [NUM_VOICES*8-1:0]  sample_out,
   output logic [NUM_VOICES-1:0]    sample_valid,
   output logic                     busy,
   output logic                     overrun
);

   // state     | meaning
   // S_IDLE    | waiting for sample_tick
   // S_ISSUE   | sample_now high, operands presented to divider
   // S_WAIT    | divider computing, down-counter running
   // S_CAPTURE | quotient latched on exit, next voice or round end chosen
   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ISSUE   = 2'd1;
   localparam logic [1:0] S_WAIT    = 2'd2;
   localparam logic [1:0] S_CAPTURE = 2'd3;

   localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam int CW = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY + 1) : 1;
   localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_VOICES - 1);
   localparam logic [CW-1:0] WAIT_LOAD = CW'(DIV_LATENCY - 1);

   logic [1:0]            state;
   logic [NUM_VOICES-1:0] pending;
   logic [IW-1:0]         voice;
   logic [IW-1:0]         start_idx;
   logic [CW-1:0]         wait_cnt;
   logic                  zero_div;

   logic [NUM_VOICES-1:0] rem_mask;
   logic [NUM_VOICES-1:0] launch_mask;
   logic [IW-1:0]         launch_start;
   logic [IW-1:0]         start_next;
   logic [IW-1:0]         sel_idx;
   logic [IW:0]           cand;
   logic [15:0]           sel_count;
   logic [15:0]           sel_div;
   logic                  launch;
   logic                  round_done;
   logic                  overrun_set;

   // A tick landing on the round's final capture edge starts the next round instead of overrunning.
   always_comb begin
      rem_mask   = pending & ~(NUM_VOICES'(1) << voice);
      round_done = (state == S_CAPTURE) && (rem_mask == '0);
`ifdef DIV_SCHED_ROTATE_EN
      start_next = (start_idx == LAST_IDX) ? '0 : start_idx + IW'(1);
`else
      start_next = '0;
`endif
      launch       = 1'b0;
      launch_mask  = voice_en;
      launch_start = start_idx;
      if (state == S_IDLE) begin
         launch = sample_tick && (voice_en != '0);
      end else if (state == S_CAPTURE) begin
         if (rem_mask != '0) begin
            launch      = 1'b1;
            launch_mask = rem_mask;
         end else begin
            launch       = sample_tick && (voice_en != '0);
            launch_start = start_next;
         end
      end
      overrun_set = sample_tick && (state != S_IDLE) && !round_done;
   end

   // Descending scan so the lowest offset from launch_start wins.
   always_comb begin
      sel_idx = '0;
      cand    = '0;
      for (int i = NUM_VOICES - 1; i >= 0; i--) begin
         cand = {1'b0, launch_start} + (IW + 1)'(i);
         if (cand >= (IW + 1)'(NUM_VOICES)) cand = cand - (IW + 1)'(NUM_VOICES);
         if (launch_mask[cand[IW-1:0]]) sel_idx = cand[IW-1:0];
      end
      sel_count = osc_count[{sel_idx, 4'b0000} +: 16];
      sel_div   = osc_divisor[{sel_idx, 4'b0000} +: 16];
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state          <= S_IDLE;
         pending        <= '0;
         voice          <= '0;
         start_idx      <= '0;
         wait_cnt       <= '0;
         zero_div       <= 1'b0;
         div_sample_now <= 1'b0;
         div_dividend   <= '0;
         div_divisor    <= '0;
         sample_out     <= '0;
         sample_valid   <= '0;
         overrun        <= 1'b0;
      end else begin
         div_sample_now <= 1'b0;
         sample_valid   <= '0;
         if (overrun_set) overrun <= 1'b1;
         else if (overrun_clr) overrun <= 1'b0;

         case (state)
            S_ISSUE: begin
               state    <= S_WAIT;
               wait_cnt <= WAIT_LOAD;
            end
            S_WAIT: begin
               if (wait_cnt == '0) state <= S_CAPTURE;
               else wait_cnt <= wait_cnt - CW'(1);
            end
            S_CAPTURE: begin
               sample_out[{voice, 3'b000} +: 8] <= zero_div ? 8'h00 : div_q;
               sample_valid[voice] <= 1'b1;
               pending <= rem_mask;
               state   <= S_IDLE;
               if (round_done) start_idx <= start_next;
            end
            default: ;
         endcase

         // Zero divisor bypasses the divider entirely; operands keep their previous values.
         if (launch) begin
            pending <= launch_mask;
            voice   <= sel_idx;
            if (sel_div == 16'h0000) begin
               state    <= S_CAPTURE;
               zero_div <= 1'b1;
            end else begin
               state          <= S_ISSUE;
               zero_div       <= 1'b0;
               div_sample_now <= 1'b1;
               div_dividend   <= (sel_count < sel_div) ? sel_count : sel_div;
               div_divisor    <= sel_div;
            end
         end
      end
   end

   assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_divider_voice_scheduler.sv
// Bench for divider_voice_scheduler: behavioural divider plus a scoreboard of expected captures.
// Expected service order follows DIV_SCHED_ROTATE_EN when it is defined.
module tb_divider_voice_scheduler;

   localparam int NV = 4;
   localparam int L  = 10;

   logic          tb_clk;
   logic          nrst;
   logic          sample_tick;
   logic [NV-1:0] voice_en;
   logic [NV*16-1:0] osc_count;
   logic [NV*16-1:0] osc_divisor;
   logic          overrun_clr;
   logic          div_sample_now;
   logic [15:0]   div_dividend;
   logic [15:0]   div_divisor;
   logic [7:0]    div_q;
   logic [NV*8-1:0] sample_out;
   logic [NV-1:0] sample_valid;
   logic          busy;
   logic          overrun;

   divider_voice_scheduler #(.NUM_VOICES(NV), .DIV_LATENCY(L)) dut (
      .clk(tb_clk), .nrst(nrst), .sample_tick(sample_tick), .voice_en(voice_en),
      .osc_count(osc_count), .osc_divisor(osc_divisor), .overrun_clr(overrun_clr),
      .div_sample_now(div_sample_now), .div_dividend(div_dividend), .div_divisor(div_divisor),
      .div_q(div_q), .sample_out(sample_out), .sample_valid(sample_valid),
      .busy(busy), .overrun(overrun)
   );

   typedef struct {
      int         voice;
      logic [7:0] sample;
      int         edge_at;
   } exp_t;

   exp_t sb[$];
   int   order_log[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   snow_cnt = 0;
   int   rot_start = 0;
   int   last_edge = 0;
   int   dly = 0;
   logic [7:0] dq_pend;

   initial begin
      tb_clk = 1'b0;
      forever #5 tb_clk = ~tb_clk;
   end

   initial begin
      forever begin
         @(posedge tb_clk);
         cyc++;
      end
   end

   // Divider: result valid 6 cycles after sample_now; out-of-contract operands give junk.
   function automatic logic [7:0] div_model(logic [15:0] a, logic [15:0] b);
      logic [31:0] t;
      if (b == 16'h0 || a > b) return 8'h5A;
      t = ({16'h0, a} << 8) / {16'h0, b};
      return (t > 32'd255) ? 8'hFF : t[7:0];
   endfunction

   initial div_q = 8'h00;
   always @(posedge tb_clk) begin
      if (div_sample_now) begin
         dq_pend <= div_model(div_dividend, div_divisor);
         dly     <= 6;
         div_q   <= 8'hA5;
      end else if (dly > 0) begin
         dly <= dly - 1;
         if (dly == 1) div_q <= dq_pend;
      end
   end

   task automatic check(string tag, int obs, int expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic set_voice(int v, int cnt, int dv);
      osc_count[16*v +: 16]   = 16'(cnt);
      osc_divisor[16*v +: 16] = 16'(dv);
   endtask

   // Expected captures for a round whose tick is sampled on edge e0.
   task automatic push_round(int e0, logic [NV-1:0] en);
      int   t;
      int   v;
      int   c;
      int   d;
      int   m;
      int   q;
      exp_t e;
      t = e0;
      for (int i = 0; i < NV; i++) begin
         v = (rot_start + i) % NV;
         if (en[v]) begin
            c = int'(osc_count[16*v +: 16]);
            d = int'(osc_divisor[16*v +: 16]);
            if (d == 0) begin
               t = t + 1;
               q = 0;
            end else begin
               t = t + L + 2;
               m = (c < d) ? c : d;
               q = (m * 256) / d;
               if (q > 255) q = 255;
            end
            e.voice   = v;
            e.sample  = 8'(q);
            e.edge_at = t;
            sb.push_back(e);
         end
      end
`ifdef DIV_SCHED_ROTATE_EN
      if (en != '0) rot_start = (rot_start + 1) % NV;
`endif
      last_edge = t;
   endtask

   task automatic do_tick(bit expect_round);
      @(negedge tb_clk);
      sample_tick = 1'b1;
      if (expect_round) push_round(cyc + 1, voice_en);
      @(negedge tb_clk);
      sample_tick = 1'b0;
   endtask

   task automatic wait_idle(string tag);
      int n;
      n = 0;
      while ((busy || sb.size() != 0) && n < 400) begin
         @(negedge tb_clk);
         n++;
      end
      check({tag, "_idle_timeout"}, int'(n < 400), 1);
   endtask

   task automatic apply_reset();
      @(negedge tb_clk);
      #2 nrst = 1'b0;
      #1;
      check("rst_sample_out", int'(sample_out != '0), 0);
      check("rst_sample_valid", int'(sample_valid), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_overrun", int'(overrun), 0);
      check("rst_sample_now", int'(div_sample_now), 0);
      check("rst_dividend", int'(div_dividend), 0);
      check("rst_divisor", int'(div_divisor), 0);
      sb.delete();
      rot_start = 0;
      @(negedge tb_clk);
      nrst = 1'b1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge tb_clk);
         if (nrst) begin
            if (div_sample_now) snow_cnt++;
            if (sample_valid != '0) begin
               check("valid_onehot", int'($onehot(sample_valid)), 1);
               if (sb.size() == 0) begin
                  check("unexpected_valid", int'(sample_valid), 0);
               end else begin
                  e = sb.pop_front();
                  check("valid_voice", int'(sample_valid), 1 << e.voice);
                  check("sample_value", int'(sample_out[8*e.voice +: 8]), int'(e.sample));
                  check("valid_edge", cyc, e.edge_at);
                  order_log.push_back(e.voice);
               end
            end
         end
      end
   end

   initial begin : stimulus
      int base;
      int n;
      int exp3[4];
      int exp6[8];
      exp3 = '{247, 250, 255, 0};
`ifdef DIV_SCHED_ROTATE_EN
      exp6 = '{0, 1, 2, 3, 1, 2, 3, 0};
`else
      exp6 = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
      nrst        = 1'b0;
      sample_tick = 1'b0;
      voice_en    = '0;
      osc_count   = '0;
      osc_divisor = '0;
      overrun_clr = 1'b0;
      repeat (2) @(negedge tb_clk);
      apply_reset();

      // single voice
      set_voice(0, 22000, 22727);
      voice_en = 4'b0001;
      base = snow_cnt;
      do_tick(1'b1);
      wait_idle("t2");
      check("t2_sample_now_count", snow_cnt - base, 1);
      check("t2_sample0", int'(sample_out[7:0]), 247);
      check("t2_busy", int'(busy), 0);

      // empty enable: no round
      voice_en = 4'b0000;
      base = snow_cnt;
      do_tick(1'b1);
      check("t2_empty_busy", int'(busy), 0);
      repeat (3) @(negedge tb_clk);
      check("t2_empty_sample_now", snow_cnt - base, 0);

      // four voices
      set_voice(1, 22256, 22727);
      set_voice(2, 22727, 22727);
      set_voice(3, 0, 22727);
      voice_en = 4'b1111;
      base = snow_cnt;
      do_tick(1'b1);
      wait_idle("t3");
      check("t3_sample_now_count", snow_cnt - base, 4);
      for (int v = 0; v < NV; v++) check("t3_sample", int'(sample_out[8*v +: 8]), exp3[v]);

      // clamp and zero divisor
      set_voice(0, 30000, 22727);
      set_voice(1, 5000, 0);
      voice_en = 4'b0011;
      base = snow_cnt;
      do_tick(1'b1);
      wait_idle("t4");
      check("t4_sample_now_count", snow_cnt - base, 1);
      check("t4_clamp_sample0", int'(sample_out[7:0]), 255);
      check("t4_zero_sample1", int'(sample_out[15:8]), 0);
      check("t4_hold_sample2", int'(sample_out[23:16]), 255);

      // reset mid-WAIT
      set_voice(0, 22000, 22727);
      voice_en = 4'b0001;
      do_tick(1'b1);
      repeat (5) @(negedge tb_clk);
      check("t1_in_round", int'(busy), 1);
      apply_reset();
      base = snow_cnt;
      repeat (30) @(negedge tb_clk);
      check("t1_no_sample_now", snow_cnt - base, 0);
      check("t1_busy_after", int'(busy), 0);

      // overrun
      set_voice(1, 22256, 22727);
      voice_en = 4'b1111;
      base = snow_cnt;
      do_tick(1'b1);
      repeat (3) @(negedge tb_clk);
      do_tick(1'b0);
      check("t5_overrun_set", int'(overrun), 1);
      overrun_clr = 1'b1;
      @(negedge tb_clk);
      overrun_clr = 1'b0;
      check("t5_overrun_clr", int'(overrun), 0);
      n = 0;
      while (cyc < last_edge - 1 && n < 200) begin
         @(negedge tb_clk);
         n++;
      end
      check("t5_align", cyc, last_edge - 1);
      sample_tick = 1'b1;
      push_round(cyc + 1, voice_en);
      @(negedge tb_clk);
      sample_tick = 1'b0;
      check("t5_edge_tick_no_overrun", int'(overrun), 0);
      check("t5_edge_tick_new_round", int'(busy), 1);
      repeat (3) @(negedge tb_clk);
      sample_tick = 1'b1;
      overrun_clr = 1'b1;
      @(negedge tb_clk);
      sample_tick = 1'b0;
      overrun_clr = 1'b0;
      check("t5_set_wins", int'(overrun), 1);
      overrun_clr = 1'b1;
      @(negedge tb_clk);
      overrun_clr = 1'b0;
      wait_idle("t5");
      check("t5_overrun_final", int'(overrun), 0);
      check("t5_sample_now_count", snow_cnt - base, 8);

      // rotation over two rounds from reset
      apply_reset();
      order_log.delete();
      voice_en = 4'b1111;
      do_tick(1'b1);
      wait_idle("t6a");
      do_tick(1'b1);
      wait_idle("t6b");
      check("t6_order_len", order_log.size(), 8);
      for (int i = 0; i < 8; i++) begin
         if (i < order_log.size()) check("t6_order", order_log[i], exp6[i]);
      end

      check("sb_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
